seq_pattern_gen: RTL
====================

Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: the stimulus-side counterpart of the sequence detectors in this area.
- Captures a PAT_W-bit pattern on a start handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeated a programmable number of times with an optional idle gap between repetitions.
- Its serial output drives the x input of a Mealy/Moore sequence detector, in place of hand-timed testbench stimulus.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- CNT_W, 4, width of the repeat and gap counters.
- IDLE_LVL, 1'b0, level driven on x_out when not sending a pattern bit.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_W  pattern to send; bit PAT_W-1 goes first.
- reps  input  CNT_W  number of pattern repetitions; 0 = send nothing.
- gap  input  CNT_W  idle cycles inserted between repetitions (not after the last).
- abort  input  1  synchronous cancel of the current transfer.
- x_out  output  1  serial data bit.
- x_valid  output  1  high when x_out carries a pattern bit.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE, x_out=IDLE_LVL, x_valid=0, busy=0, done=0.
  - All counters and shift register cleared.
  - An in-flight transfer is lost; no done pulse.
- All outputs are registered.
- FSM states:
  - IDLE
  - SEND: shift out bits.
  - GAP: inter-repetition idle.
  - FIN: single cycle, done=1.
- IDLE:
  - On edge with start=1 and reps!=0: latch pattern into the shift register, reps_left=reps, gap_len=gap, bit_cnt=PAT_W-1; go to SEND.
  - During the following cycle: x_out=pattern[PAT_W-1], x_valid=1, busy=1.
  - start=1 with reps=0: go to FIN; done pulses next cycle, no bits sent, busy stays 0.
- SEND:
  - One bit per cycle, MSB-first; bit_cnt decrements.
  - After the last bit (bit_cnt==0), reps_left decrements.
  - If reps_left becomes 0: go to FIN.
  - Else if gap_len!=0: go to GAP for exactly gap_len cycles (x_valid=0, x_out=IDLE_LVL).
  - Else: reload and continue back-to-back with no bubble.
- GAP: after gap_len cycles, reload the shift register from the latched pattern copy and return to SEND.
- FIN: done=1, busy=0, x_valid=0 for one cycle; then IDLE.
  - A start in the FIN cycle is ignored.
  - A start in the next IDLE cycle is accepted.
- Total x_valid cycles = reps*PAT_W.
- Transfer length from the first valid bit to the last = reps*PAT_W + (reps-1)*gap cycles.
- done is high on the cycle immediately after the last valid bit.
- start while busy is ignored. pattern, reps and gap are don't-care after acceptance; changing them mid-transfer has no effect.
- abort=1 (any non-IDLE state):
  - Next edge: state=IDLE, x_valid=0, x_out=IDLE_LVL, busy=0, no done pulse.
  - abort has priority over start on the same edge.
  - abort in IDLE has no effect.
- Counter widths:
  - bit_cnt is clog2(PAT_W) bits.
  - reps_left and gap counter are CNT_W bits; maximum reps = 2^CNT_W-1, no wrap.

Decomposition:
- Package seq_pkg holds:
  - State enum (IDLE, SEND, GAP, FIN).
  - Shared constant DEF_PAT_1010 = 4'b1010, used by generator and detector benches.
- One natural sub-module: seq_shift_out, a loadable PAT_W-bit parallel-in/serial-out register with load and shift enables.
- The FSM and counters stay in the top.

Test Plan:
- Reset mid-transfer: pattern=1010, reps=2, assert rst=0 during bit 2 -> x_valid=0, busy=0, x_out=IDLE_LVL immediately; no done afterwards.
- Single shot: pattern=1010, reps=1, gap=0 -> x_out=1,0,1,0 on 4 consecutive x_valid cycles starting the cycle after start; done pulses on cycle 5.
- Back-to-back repeats: pattern=1010, reps=3, gap=0 -> 12 contiguous valid bits 101010101010. A chained non-overlapping 1010 detector pulses z exactly 3 times.
- Gap insertion: pattern=1101, reps=2, gap=2 -> 1101, two cycles x_valid=0, then 1101; done on cycle 11.
- Abort/ignore: start while busy ignored (bit stream unchanged); abort in bit 3 of reps=2 -> idle next cycle, no done. reps=0 start -> done next cycle, zero valid bits.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the sequence-detector benches.
package seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StSend = 2'd1;
  localparam state_t StGap  = 2'd2;
  localparam state_t StFin  = 2'd3;

  localparam logic [3:0] DEF_PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_shift_out.sv
// Loadable parallel-in/serial-out register; exposes the bit that becomes the MSB after a shift.
module seq_shift_out #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic             next_bit_o
);

  logic [Width-1:0] sr_q;

  // Rotating keeps every bit live; the top reloads between repetitions anyway.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[Width-2:0], sr_q[Width-1]};
    end
  end

  assign next_bit_o = sr_q[Width-2];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, reps times, with optional gaps.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    BW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0]  BitLast = BW'(PAT_W - 1);

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] reps_left_q, reps_left_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] load_val;
  logic             sr_load, sr_shift, sr_next_bit;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  seq_shift_out #(
    .Width(PAT_W)
  ) u_shift (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (sr_load),
    .shift_i   (sr_shift),
    .data_i    (load_val),
    .next_bit_o(sr_next_bit)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    reps_left_d = reps_left_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    pat_d       = pat_q;
    load_val    = pat_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (reps != '0) begin
            load_val    = pattern;
            pat_d       = pattern;
            sr_load     = 1'b1;
            reps_left_d = reps;
            gap_len_d   = gap;
            bit_cnt_d   = BitLast;
            state_d     = StSend;
          end else begin
            state_d = StFin;
          end
        end
      end
      StSend: begin
        if (bit_cnt_q != '0) begin
          sr_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else begin
          reps_left_d = reps_left_q - 1'b1;
          if (reps_left_q == CNT_W'(1)) begin
            state_d = StFin;
          end else if (gap_len_q != '0) begin
            gap_cnt_d = gap_len_q - 1'b1;
            state_d   = StGap;
          end else begin
            sr_load   = 1'b1;
            bit_cnt_d = BitLast;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          sr_load   = 1'b1;
          bit_cnt_d = BitLast;
          state_d   = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Cancel wins over everything else, including a same-edge reload.
    if (abort && (state_q != StIdle)) begin
      state_d  = StIdle;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
    end

    // Outputs are precomputed from the next state so they come straight from flops.
    x_valid_d = (state_d == StSend);
    busy_d    = (state_d == StSend) || (state_d == StGap);
    done_d    = (state_d == StFin);
    if (state_d == StSend) begin
      x_out_d = sr_load ? load_val[PAT_W-1] : sr_next_bit;
    end else begin
      x_out_d = IDLE_LVL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      reps_left_q <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      pat_q       <= '0;
      x_out_q     <= IDLE_LVL;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      reps_left_q <= reps_left_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      pat_q       <= pat_d;
      x_out_q     <= x_out_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
